// File: rtl/serial_sub_sequencer.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single 1-bit borrow-lookahead cell is reused for every bit position.
// The controller holds the operands and the running borrow, counts the bit
// position, and reports completion with a busy/done handshake.

// One-bit subtract cell in generate/propagate form.
// A borrow is generated when a=0 and b=1. An incoming borrow is passed on
// when a == b.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic gen;
    logic prop;

    assign gen  = ~a & b;
    assign prop = ~(a ^ b);
    assign d    = a ^ b ^ bin;
    assign bout = gen | (prop & bin);
endmodule

module serial_sub_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shift;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] result;
    logic             last_bit;

    serial_sub_cell u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The full result includes the bit being produced this cycle. That lets
    // diff load on the same edge that processes the MSB.
    assign result   = {cell_d, shift[WIDTH-1:1]};
    assign last_bit = (count == CW'(WIDTH - 1));

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            shift  <= '0;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Capture a fresh operation. diff, bout and zero
                        // keep the previous result until the next completion.
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    shift  <= result;
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    borrow <= cell_bout;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        diff  <= result;
                        bout  <= cell_bout;
                        zero  <= (result == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Self-checking bench for serial_sub_sequencer.
// It uses directed vectors plus random operations checked against an
// arithmetic reference model.
module tb_serial_sub_sequencer;
    localparam int W  = 8;
    localparam int CW = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_sub_sequencer #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer subtraction.
    // The result is {borrow_out, diff mod 2^W}.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        longint       v;
        logic [W-1:0] r;
        v = longint'(x) - longint'(y) - longint'(c);
        r = v[W-1:0];
        return {(v < 0), r};
    endfunction

    // Present one start pulse, then scramble the operands.
    // On return the time is the falling edge just after the accepting edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    // Bounded wait for done.
    // k counts falling edges since acceptance, and the first falling edge is 1.
    task automatic wait_done(output int k);
        k = 1;
        while (done !== 1'b1 && k < 4 * W) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b diff=%h bout=%b zero=%b, want all 0",
                     busy, done, diff, bout, zero);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
            errors++;
            $display("FAIL reset_held: busy=%b done=%b diff=%h, want 0", busy, done, diff);
        end
        reset = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_directed;
        logic [W-1:0] va  [4] = '{8'h5A, 8'h00, 8'h10, 8'h00};
        logic [W-1:0] vb  [4] = '{8'h3C, 8'h01, 8'h0F, 8'h00};
        logic         vc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] ed  [4] = '{8'h1E, 8'hFF, 8'h00, 8'hFF};
        logic         eb  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         ez  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int k;
            int busy_cnt;
            start_op(va[i], vb[i], vc[i]);
            k        = 1;
            busy_cnt = 0;
            while (done !== 1'b1 && k < 4 * W) begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                k++;
            end
            checks++;
            if (k != W + 1 || busy_cnt != W) begin
                errors++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d, want %0d and %0d",
                         i, k, busy_cnt, W + 1, W);
            end
            checks++;
            if (diff !== ed[i] || bout !== eb[i] || zero !== ez[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_result[%0d]: diff=%h bout=%b zero=%b busy=%b, want %h %b %b 0",
                         i, diff, bout, zero, busy, ed[i], eb[i], ez[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || diff !== ed[i]) begin
                errors++;
                $display("FAIL directed_pulse[%0d]: done=%b diff=%h, want 0 and %h",
                         i, done, diff, ed[i]);
            end
            $display("directed: a=%h b=%h bin=%b -> diff=%h bout=%b zero=%b",
                     va[i], vb[i], vc[i], diff, bout, zero);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            logic         c;
            logic [W:0]   e;
            int           k;
            av = W'($urandom);
            bv = (i % 5 == 0) ? av : W'($urandom);
            c  = 1'($urandom);
            e  = ref_sub(av, bv, c);
            start_op(av, bv, c);
            wait_done(k);
            checks++;
            if (k != W + 1 || diff !== e[W-1:0] || bout !== e[W] || zero !== (e[W-1:0] == '0)) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h bin=%b lat=%0d diff=%h bout=%b zero=%b, want lat=%0d %h %b %b",
                         i, av, bv, c, k, diff, bout, zero, W + 1, e[W-1:0], e[W], (e[W-1:0] == '0));
            end
            $display("random: a=%h b=%h bin=%b -> diff=%h bout=%b", av, bv, c, diff, bout);
        end
    endtask

    task automatic test_lockout;
        int pulses;
        int k;
        start_op(8'h80, 8'h01, 1'b0);
        pulses = 0;
        k      = 1;
        // Pulse start and toggle the operands while the operation is running.
        // Stop before the DONE-state edge, because a start there is legal.
        while (k < W - 1) begin
            start = k[0];
            a     = k[0] ? 8'hFF : 8'h00;
            b     = k[0] ? 8'hFF : 8'h00;
            bin   = k[0];
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        wait_done(k);
        checks++;
        if (diff !== 8'h7F || bout !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL lockout_result: diff=%h bout=%b zero=%b, want 7f 0 0", diff, bout, zero);
        end
        for (int i = 0; i < 2 * W; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_pulses: done_pulses=%0d busy=%b, want 1 and 0", pulses, busy);
        end
        $display("lockout: diff=%h bout=%b pulses=%0d", diff, bout, pulses);
    endtask

    task automatic test_back_to_back;
        int k;
        int gap;
        int held_bad;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h01;
        bin   = 1'b0;
        @(negedge clk);
        // Start stays high. The new operands must wait for the DONE-state edge.
        a = 8'h01;
        b = 8'h03;
        wait_done(k);
        checks++;
        if (k != W + 1 || diff !== 8'h02 || bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d diff=%h bout=%b, want %0d 02 0", k, diff, bout, W + 1);
        end
        @(negedge clk);
        start    = 1'b0;
        gap      = 1;
        held_bad = 0;
        while (done !== 1'b1 && gap < 4 * W) begin
            if (diff !== 8'h02 || bout !== 1'b0) held_bad++;
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap != W + 1 || held_bad != 0) begin
            errors++;
            $display("FAIL b2b_gap: gap=%0d held_bad=%0d, want %0d and 0", gap, held_bad, W + 1);
        end
        checks++;
        if (diff !== 8'hFE || bout !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: diff=%h bout=%b zero=%b, want fe 1 0", diff, bout, zero);
        end
        $display("back_to_back: gap=%0d second diff=%h bout=%b", gap, diff, bout);
    endtask

    task automatic test_reset_mid;
        int pulses;
        int k;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (diff !== '0 || bout !== 1'b0 || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: diff=%h bout=%b zero=%b busy=%b done=%b, want all 0",
                     diff, bout, zero, busy, done);
        end
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy/done seen %0d times, want 0", pulses);
        end
        start_op(8'h09, 8'h09, 1'b0);
        wait_done(k);
        checks++;
        if (k != W + 1 || diff !== 8'h00 || zero !== 1'b1 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: lat=%0d diff=%h zero=%b bout=%b, want %0d 00 1 0",
                     k, diff, zero, bout, W + 1);
        end
        $display("reset_mid: follow-up diff=%h zero=%b", diff, zero);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_lockout;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
